// File: rtl/count_checker.sv
// -----------------------------------------------------------------------------
// count_checker
//
// Passive monitor for an up-counter's count/tc interface. Each rising edge it
// samples the observed counter reset, enable, count and terminal-count flag,
// locks onto the sequence and flags any step that breaks the counter rules:
// increment and wrap at MAX_VALUE, hold when disabled, clear on reset, and
// tc high exactly when count equals MAX_VALUE.
//
// Parameters:
//   WIDTH      width of the observed count
//   MAX_VALUE  terminal value, counter wraps MAX_VALUE -> 0
//   RESYNC     1: relock automatically after an error, 0: park in FAULT
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset of the checker
//   mon_rst    in   observed counter reset (active-high)
//   mon_en     in   observed counter enable
//   mon_count  in   observed counter value
//   mon_tc     in   observed terminal-count flag
//   clear      in   synchronous clear of error state and statistics
//   locked     out  checker is tracking the sequence
//   err_pulse  out  one-cycle pulse per detected violation
//   err_sticky out  set on any violation, held until clear/reset
//   err_code   out  first violation cause: 01 sequence, 10 tc, 11 both
//   err_cnt    out  saturating violation count
//   wrap_cnt   out  wrap events seen while locked, modulo 2^16
//
// Build option: COUNT_CHECKER_WRAP_CNT_EN builds the wrap counter; without it
// wrap_cnt is tied to zero.
// -----------------------------------------------------------------------------
module count_checker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 9,
  parameter bit          RESYNC    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_rst,
  input  logic             mon_en,
  input  logic [WIDTH-1:0] mon_count,
  input  logic             mon_tc,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [1:0]       err_code,
  output logic [7:0]       err_cnt,
  output logic [15:0]      wrap_cnt
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);
  localparam logic [7:0]       CNT_SAT = 8'hFF;

  // Value the counter must present on the next edge, given this sample.
  // The increment is formed one bit wider so it cannot overflow silently.
  function automatic logic [WIDTH-1:0] next_expected(
    input logic [WIDTH-1:0] cnt,
    input logic             en,
    input logic             rs
  );
    logic [WIDTH:0] inc;
    inc = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
    if (rs) begin
      return {WIDTH{1'b0}};
    end else if (en && (cnt == MAX_W)) begin
      return {WIDTH{1'b0}};
    end else if (en) begin
      return inc[WIDTH-1:0];
    end else begin
      return cnt;
    end
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic tc_ok_s, in_range_s, seq_err_s, tc_err_s, viol_s;

  // Per-sample rule evaluation against the held reference.
  always_comb begin
    tc_ok_s    = (mon_tc == (mon_count == MAX_W));
    in_range_s = (mon_count <= MAX_W);
    seq_err_s  = (mon_count != exp_q) || !in_range_s;
    tc_err_s   = !tc_ok_s;
    viol_s     = (state_q == ST_LOCKED) && (seq_err_s || tc_err_s);
  end

  // Next-state and error bookkeeping; clear overrides everything, including
  // a violation found on the same edge.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    err_code_d   = err_code_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      ST_UNSYNC: begin
        if (in_range_s && tc_ok_s) begin
          state_d = ST_LOCKED;
          exp_d   = next_expected(mon_count, mon_en, mon_rst);
        end else begin
          state_d = ST_UNSYNC;
        end
      end
      ST_LOCKED: begin
        if (viol_s) begin
          state_d = RESYNC ? ST_UNSYNC : ST_FAULT;
        end else begin
          exp_d = next_expected(mon_count, mon_en, mon_rst);
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_UNSYNC;
      end
    endcase

    if (clear) begin
      state_d      = ST_UNSYNC;
      err_sticky_d = 1'b0;
      err_code_d   = 2'b00;
      err_cnt_d    = 8'd0;
    end else if (viol_s) begin
      err_pulse_d  = 1'b1;
      err_sticky_d = 1'b1;
      if (err_code_q == 2'b00) begin
        err_code_d = {tc_err_s, seq_err_s};
      end else begin
        err_code_d = err_code_q;
      end
      if (err_cnt_q != CNT_SAT) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_pulse_d = 1'b0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // Checker state, reference and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_UNSYNC;
      exp_q        <= {WIDTH{1'b0}};
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= 2'b00;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_code_q   <= err_code_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_code   = err_code_q;
  assign err_cnt    = err_cnt_q;

`ifdef COUNT_CHECKER_WRAP_CNT_EN
  logic [15:0] wrap_q, wrap_d;
  logic        wrap_hit_s;

  // A wrap is a locked sample at terminal count that is about to roll over.
  always_comb begin
    wrap_hit_s = (state_q == ST_LOCKED) && (mon_count == MAX_W) && mon_en && !mon_rst;
    if (clear) begin
      wrap_d = 16'd0;
    end else if (wrap_hit_s) begin
      wrap_d = wrap_q + 16'd1;
    end else begin
      wrap_d = wrap_q;
    end
  end

  // Wrap counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 16'd0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_cnt = wrap_q;
`else
  assign wrap_cnt = 16'd0;
`endif

endmodule
